// File: rtl/alu_pkg.sv
// Shared definitions for the integer ALU: operation codes, flag bit positions, shifter modes.
// Latency: none (declarations only).
// Backpressure: not applicable.
package alu_pkg;

    // Operation select, equal to {funct7[5], funct3}
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    // Bit positions inside the 4-bit {V,C,N,Z} flag vector
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    // Barrel shifter mode select
    localparam logic [1:0] SHIFT_SLL = 2'b00;
    localparam logic [1:0] SHIFT_SRL = 2'b01;
    localparam logic [1:0] SHIFT_SRA = 2'b10;

endpackage

// File: rtl/alu_shifter.sv
// Logarithmic barrel shifter: left logical, right logical and right arithmetic.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs continuously.
module alu_shifter
    import alu_pkg::*;
#(
    parameter int N  = 32,
    parameter int SW = $clog2(N)
) (
    input  logic [N-1:0]  i_a,
    input  logic [SW-1:0] i_shamt,
    input  logic [1:0]    i_mode,
    output logic [N-1:0]  o_result
);

    logic [N-1:0] w_val;

    // One stage per shift-amount bit; stage i moves the value by 2**i positions
    always_comb begin
        w_val = i_a;
        for (int i = 0; i < SW; i++) begin
            if (i_shamt[i]) begin
                case (i_mode)
                    SHIFT_SLL: w_val = w_val << (1 << i);
                    SHIFT_SRL: w_val = w_val >> (1 << i);
                    SHIFT_SRA: w_val = $signed(w_val) >>> (1 << i);
                    default:   w_val = w_val;
                endcase
            end
        end
    end

    assign o_result = w_val;

endmodule

// File: rtl/alu_unit.sv
// RV32I-style integer ALU with combinational result/flags and an enable-gated registered copy.
// Latency: RESULT/ZERO/FLAGS zero cycles; RESULT_Q/FLAGS_Q one clk edge after EN=1.
// Backpressure: none; EN=0 simply holds the registered copy.
module alu_unit
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [3:0]   OP,
    input  logic         EN,
    output logic [N-1:0] RESULT,
    output logic         ZERO,
    output logic [3:0]   FLAGS,
    output logic [N-1:0] RESULT_Q,
    output logic [3:0]   FLAGS_Q
);

    localparam int SW = $clog2(N);

    logic         w_sub;
    logic [N-1:0] w_b_op;
    logic [N:0]   w_sum;
    logic         w_carry;
    logic         w_ovf;
    logic [1:0]   w_shift_mode;
    logic [N-1:0] w_shift;
    logic [N-1:0] w_result;
    logic [3:0]   w_flags;
    logic [N-1:0] r_result_q;
    logic [3:0]   r_flags_q;

    // ADD, SUB and both compares share one N+1-bit adder; subtraction is A + ~B + 1
    assign w_sub   = (OP == ALU_SUB) || (OP == ALU_SLT) || (OP == ALU_SLTU);
    assign w_b_op  = w_sub ? ~B : B;
    assign w_sum   = {1'b0, A} + {1'b0, w_b_op} + {{N{1'b0}}, w_sub};
    assign w_carry = w_sum[N];
    // Overflow: adder inputs agree in sign but the sum's sign differs from them
    assign w_ovf   = (A[N-1] == w_b_op[N-1]) && (w_sum[N-1] != A[N-1]);

    assign w_shift_mode = (OP == ALU_SLL) ? SHIFT_SLL :
                          (OP == ALU_SRA) ? SHIFT_SRA : SHIFT_SRL;

    alu_shifter #(
        .N  (N),
        .SW (SW)
    ) u_shifter (
        .i_a      (A),
        .i_shamt  (B[SW-1:0]),
        .i_mode   (w_shift_mode),
        .o_result (w_shift)
    );

    // Result select; unused opcodes yield zero
    always_comb begin
        w_result = '0;
        case (OP)
            ALU_ADD, ALU_SUB:           w_result = w_sum[N-1:0];
            ALU_SLT:                    w_result = {{(N-1){1'b0}}, w_sum[N-1] ^ w_ovf};
            ALU_SLTU:                   w_result = {{(N-1){1'b0}}, ~w_carry};
            ALU_SLL, ALU_SRL, ALU_SRA:  w_result = w_shift;
            ALU_XOR:                    w_result = A ^ B;
            ALU_OR:                     w_result = A | B;
            ALU_AND:                    w_result = A & B;
            default:                    w_result = '0;
        endcase
    end

    // Flags: Z and N for every op, C and V only meaningful for ADD/SUB
    always_comb begin
        w_flags         = '0;
        w_flags[FLAG_Z] = (w_result == '0);
        w_flags[FLAG_N] = w_result[N-1];
        if ((OP == ALU_ADD) || (OP == ALU_SUB)) begin
            w_flags[FLAG_C] = w_carry;
            w_flags[FLAG_V] = w_ovf;
        end
    end

    // Registered copy for pipelined consumers; reset clears it asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_result_q <= '0;
            r_flags_q  <= '0;
        end else if (EN) begin
            r_result_q <= w_result;
            r_flags_q  <= w_flags;
        end
    end

    assign RESULT   = w_result;
    assign ZERO     = w_flags[FLAG_Z];
    assign FLAGS    = w_flags;
    assign RESULT_Q = r_result_q;
    assign FLAGS_Q  = r_flags_q;

endmodule

// File: tb/tb_alu_unit.sv
// Testbench for alu_unit: directed vector table, register-stage sequences, random sweep.
// Latency: checks combinational outputs 1ns after inputs change, registered outputs 1ns after posedge.
// Backpressure: not applicable.
module tb_alu_unit;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  OP;
    logic        EN;
    logic [31:0] RESULT;
    logic        ZERO;
    logic [3:0]  FLAGS;
    logic [31:0] RESULT_Q;
    logic [3:0]  FLAGS_Q;

    int errors = 0;
    int checks = 0;

    alu_unit #(.N(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .A        (A),
        .B        (B),
        .OP       (OP),
        .EN       (EN),
        .RESULT   (RESULT),
        .ZERO     (ZERO),
        .FLAGS    (FLAGS),
        .RESULT_Q (RESULT_Q),
        .FLAGS_Q  (FLAGS_Q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  fl;   // {V,C,N,Z}
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Reference model: integer arithmetic straight from the operation definitions
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                                  output logic [31:0] res, output logic [3:0] fl);
        longint sa, sb, s;
        logic [32:0] wide;
        logic c, v;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        c   = 1'b0;
        v   = 1'b0;
        res = 32'h0;
        case (op)
            4'b0000: begin
                wide = {1'b0, a} + {1'b0, b};
                res  = wide[31:0];
                c    = wide[32];
                s    = sa + sb;
                v    = (s != longint'($signed(res)));
            end
            4'b1000: begin
                res = a - b;
                c   = (a >= b);
                s   = sa - sb;
                v   = (s != longint'($signed(res)));
            end
            4'b0001: res = a << b[4:0];
            4'b0010: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0011: res = (a < b) ? 32'd1 : 32'd0;
            4'b0100: res = a ^ b;
            4'b0101: res = a >> b[4:0];
            4'b1101: res = $signed(a) >>> b[4:0];
            4'b0110: res = a | b;
            4'b0111: res = a & b;
            default: res = 32'h0;
        endcase
        fl = {v, c, res[31], (res == 32'h0)};
    endfunction

    task automatic apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        OP = op;
        A  = a;
        B  = b;
        #1;
    endtask

    initial begin
        logic [31:0] edges[6];
        logic [31:0] m_res;
        logic [3:0]  m_fl;
        logic [31:0] ra, rb;
        logic [3:0]  rop;

        edges[0] = 32'h0;        edges[1] = 32'h1;        edges[2] = 32'h7FFFFFFF;
        edges[3] = 32'h80000000; edges[4] = 32'hFFFFFFFF; edges[5] = 32'h5;

        vecs[0]  = '{ALU_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0101};
        vecs[1]  = '{ALU_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1010};
        vecs[2]  = '{ALU_SUB,  32'h00000005, 32'h00000005, 32'h00000000, 4'b0101};
        vecs[3]  = '{ALU_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 4'b0000};
        vecs[4]  = '{ALU_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0001};
        vecs[5]  = '{ALU_SRA,  32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 4'b0010};
        vecs[6]  = '{ALU_SRL,  32'h80000000, 32'h0000001F, 32'h00000001, 4'b0000};
        vecs[7]  = '{ALU_SLL,  32'h00000001, 32'h00000023, 32'h00000008, 4'b0000};
        vecs[8]  = '{ALU_AND,  32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000000, 4'b0001};
        vecs[9]  = '{ALU_OR,   32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 4'b0010};
        vecs[10] = '{4'b1111,  32'h12345678, 32'h9ABCDEF0, 32'h00000000, 4'b0001};
        vecs[11] = '{ALU_SUB,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b0010};
        vecs[12] = '{ALU_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b1100};
        vecs[13] = '{ALU_XOR,  32'hA5A5A5A5, 32'hFFFFFFFF, 32'h5A5A5A5A, 4'b0000};
        vecs[14] = '{ALU_SLL,  32'h12345678, 32'h00000020, 32'h12345678, 4'b0000};
        vecs[15] = '{4'b1001,  32'h00000001, 32'h00000001, 32'h00000000, 4'b0001};

        // Reset dominates an enabled capture
        reset = 1'b1;
        EN    = 1'b1;
        OP    = ALU_ADD;
        A     = 32'd2;
        B     = 32'd3;
        repeat (2) @(posedge clk);
        #1;
        check("reset result_q", RESULT_Q, 32'h0);
        check("reset flags_q", {28'h0, FLAGS_Q}, 32'h0);

        // Release between edges; capture happens only at the following edge
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("release no capture", RESULT_Q, 32'h0);
        @(posedge clk);
        #1;
        check("en add 2+3 result_q", RESULT_Q, 32'd5);
        check("en add 2+3 flags_q", {28'h0, FLAGS_Q}, 32'h0);

        // Directed table, register stage held off
        @(negedge clk);
        EN = 1'b0;
        for (int i = 0; i < 16; i++) begin
            apply(vecs[i].op, vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d result", i), RESULT, vecs[i].res);
            check($sformatf("vec%0d zero", i), {31'h0, ZERO}, {31'h0, vecs[i].fl[0]});
            check($sformatf("vec%0d flags", i), {28'h0, FLAGS}, {28'h0, vecs[i].fl});
        end
        check("hold over table", RESULT_Q, 32'd5);

        // Random sweep against the reference model
        for (int n = 0; n < 3000; n++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
            apply(rop, ra, rb);
            model(ra, rb, rop, m_res, m_fl);
            check($sformatf("rand%0d op=%h a=%h b=%h result", n, rop, ra, rb), RESULT, m_res);
            check($sformatf("rand%0d op=%h a=%h b=%h zero", n, rop, ra, rb), {31'h0, ZERO}, {31'h0, m_fl[0]});
            check($sformatf("rand%0d op=%h a=%h b=%h flags", n, rop, ra, rb), {28'h0, FLAGS}, {28'h0, m_fl});
        end

        // EN=0 with new inputs holds
        apply(ALU_SUB, 32'd100, 32'd1);
        @(posedge clk);
        #1;
        check("en0 hold result_q", RESULT_Q, 32'd5);
        check("en0 hold flags_q", {28'h0, FLAGS_Q}, 32'h0);

        // Captured flags follow the combinational flags
        apply(ALU_ADD, 32'hFFFFFFFF, 32'h1);
        EN = 1'b1;
        @(posedge clk);
        #1;
        check("carry capture result_q", RESULT_Q, 32'h0);
        check("carry capture flags_q", {28'h0, FLAGS_Q}, 32'h5);
        apply(ALU_ADD, 32'h7FFFFFFF, 32'h1);
        @(posedge clk);
        #1;
        check("ovf capture result_q", RESULT_Q, 32'h80000000);
        check("ovf capture flags_q", {28'h0, FLAGS_Q}, 32'hA);
        apply(ALU_ADD, 32'd7, 32'd8);
        @(posedge clk);
        #1;
        check("pre-reset capture", RESULT_Q, 32'd15);

        // Asynchronous reset between edges clears at once and discards the pending capture
        apply(ALU_ADD, 32'h80000000, 32'h80000000);
        reset = 1'b1;
        #1;
        check("async reset result_q", RESULT_Q, 32'h0);
        check("async reset flags_q", {28'h0, FLAGS_Q}, 32'h0);
        check("comb during reset", RESULT, 32'h0);
        check("comb flags during reset", {28'h0, FLAGS}, 32'hD);
        @(posedge clk);
        #1;
        check("reset discards capture", RESULT_Q, 32'h0);
        check("reset discards flags", {28'h0, FLAGS_Q}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        A     = 32'd7;
        B     = 32'd8;
        @(posedge clk);
        #1;
        check("post-reset capture", RESULT_Q, 32'd15);
        check("post-reset flags", {28'h0, FLAGS_Q}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
